// File: rtl/three_wire_arbiter.sv
// three_wire_arbiter
// Round-robin arbiter that lets N requesters share one three-wire serializer.
// Each frame goes through grant, a one-cycle write strobe, the serializer
// busy window, an ack to the owner, and an enforced idle gap (cs-high time).
// Optional build macro: TW_ARB_TIMEOUT_EN. When defined, a serializer that
// never raises busy is abandoned after START_WAIT cycles and err latches high.
// When undefined, the arbiter waits for busy forever and err is tied low.

module three_wire_arbiter #(
    parameter int N          = 4,
    parameter int BITS       = 16,
    parameter int START_WAIT = 64,
    parameter int GAP        = 8,
    localparam int GW        = (N > 1) ? $clog2(N) : 1,
    localparam int CMAX      = (START_WAIT > GAP) ? START_WAIT : GAP,
    localparam int CW        = $clog2(CMAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [N*BITS-1:0] req_data,
    output logic [N-1:0]      ack,
    output logic              tw_write,
    output logic [BITS-1:0]   tw_din,
    input  logic              tw_busy,
    output logic              active,
    output logic [GW-1:0]     grant_id,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    // Number of requesters expressed in the width of the rotation sum.
    localparam logic [GW:0]   N_SUM    = (GW + 1)'(N);
    localparam logic [GW-1:0] LAST_ID  = GW'(N - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
`ifdef TW_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] SW_LAST  = CW'(START_WAIT - 1);
`endif

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   ptr_nxt;
    logic [GW-1:0]   grant_nxt;
    logic [BITS-1:0] din_nxt;
    logic [N-1:0]    ack_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    logic [BITS-1:0] words [0:N-1];
    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [GW:0]     rot_sum;
    logic [N-1:0]    ack_vec;
    logic [GW-1:0]   ptr_adv;

`ifdef TW_ARB_TIMEOUT_EN
    logic            err_q;
    logic            err_nxt;
`endif

    // Split the flat request bus into one word per requester.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            words[i] = req_data[i*BITS +: BITS];
        end
    end

    // Round-robin search: first asserted request at or above the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rot_sum    = '0;
        for (int i = 0; i < N; i++) begin
            rot_sum = {1'b0, ptr} + (GW + 1)'(i);
            if (rot_sum >= N_SUM) begin
                rot_sum = rot_sum - N_SUM;
            end
            if (!pick_found && req[rot_sum[GW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = rot_sum[GW-1:0];
            end
        end
    end

    // Ack pattern for the current owner and the pointer value just past it.
    always_comb begin
        ack_vec = N'(1) << grant_id;
        if (grant_id == LAST_ID) begin
            ptr_adv = '0;
        end else begin
            ptr_adv = grant_id + 1'b1;
        end
    end

    // Next-state and next-register logic for the frame sequencer.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant_id;
        din_nxt   = tw_din;
        ack_nxt   = '0;
        cnt_nxt   = cnt;
`ifdef TW_ARB_TIMEOUT_EN
        err_nxt   = err_q;
`endif
        case (state)
            S_IDLE: begin
                // Foreign traffic on the serializer blocks a new grant.
                if (pick_found && !tw_busy) begin
                    grant_nxt = pick_idx;
                    din_nxt   = words[pick_idx];
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (tw_busy) begin
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT_DONE;
                end
`ifdef TW_ARB_TIMEOUT_EN
                else if (cnt == SW_LAST) begin
                    err_nxt   = 1'b1;
                    ack_nxt   = ack_vec;
                    ptr_nxt   = ptr_adv;
                    cnt_nxt   = '0;
                    state_nxt = S_GAP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            S_WAIT_DONE: begin
                if (!tw_busy) begin
                    ack_nxt   = ack_vec;
                    ptr_nxt   = ptr_adv;
                    cnt_nxt   = '0;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            grant_id <= '0;
            tw_din   <= '0;
            ack      <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant_id <= grant_nxt;
            tw_din   <= din_nxt;
            ack      <= ack_nxt;
            cnt      <= cnt_nxt;
        end
    end

`ifdef TW_ARB_TIMEOUT_EN
    // Sticky start-timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign tw_write = (state == S_ISSUE);
    assign active   = (state != S_IDLE);

endmodule

// File: doc/three_wire_arbiter.md
Name: three_wire_arbiter

Overview:
- Shares one 16-bit three-wire serializer (write/din/busy interface, chip-select-framed, divided sclk) between N requesters.
- Round-robin grant; issues a one-cycle write strobe with the granted word, tracks the serializer's busy frame to completion, acks the requester, then enforces an inter-frame gap.
- Sits between control logic (DAC/attenuator setters) and the single serializer instance in the feedback datapath.

Parameters:
- N, 4, number of requesters (2..8).
- BITS, 16, word width; must match serializer.
- START_WAIT, 64, max clk cycles from write strobe to busy rising (covers up to 2^CLK_DIVIDE*2 sclk latency).
- GAP, 8, minimum clk cycles of idle between busy falling and next write strobe (cs-high time).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  level request per requester; held until ack.
- req_data  in  N*BITS  word per requester; slice i = bits [i*BITS +: BITS]; sampled at grant.
- ack  out  N  one-cycle pulse to requester i when its frame has fully shifted out (busy fell).
- tw_write  out  1  one-cycle write strobe to serializer.
- tw_din  out  BITS  word to serializer; valid in cycle tw_write=1, held afterwards.
- tw_busy  in  1  serializer busy (cs low).
- active  out  1  high from grant until end of gap.
- grant_id  out  clog2(N) (min 1)  index of current/last grant.
- err  out  1  sticky start-timeout flag (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): state IDLE, ack=0, tw_write=0, tw_din=0, active=0, grant_id=0, err=0, round-robin pointer=0 (requester 0 highest priority first).
- tw_busy is synchronous to clk (serializer derives sclk from the same clk); no synchronizer needed.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP.
- IDLE: if any req bit set, pick first set bit searching from pointer upward with wrap; latch index into grant_id, latch slice into tw_din; go ISSUE. active rises the same edge.
- ISSUE: tw_write=1 for exactly this cycle; go WAIT_START; clear counter.
- WAIT_START: wait tw_busy=1, then go WAIT_DONE. Counter increments each cycle; behaviour at START_WAIT per Optional Feature.
- WAIT_DONE: on tw_busy=0, pulse ack[grant_id] for one cycle, pointer <= grant_id+1 (wrap to 0 at N), go GAP; clear counter.
- GAP: count GAP cycles, then IDLE, active=0. An arbitration decision in IDLE can occur on the cycle after GAP ends; back-to-back frames therefore have a write-to-write spacing of frame length + GAP + 3 cycles minimum.
- Requester dropping req after grant: frame still completes, ack still pulses (requester may ignore). req changes during a frame do not affect the current grant.
- Simultaneous requests: strict rotation; requester holding req continuously cannot be granted twice while another is pending.
- tw_busy already high in IDLE (foreign traffic): arbiter does not leave IDLE until tw_busy=0.
- rst_n asserted mid-frame: immediate return to reset state; no ack; serializer frame left to finish on its own.
- At most one ack bit high in any cycle; tw_write never high outside ISSUE.

Optional Feature:
- Macro TW_ARB_TIMEOUT_EN.
- Defined: in WAIT_START, if counter reaches START_WAIT with tw_busy still 0, set err (sticky until reset), pulse ack[grant_id] anyway, advance pointer, go GAP. Prevents lockup on a dead serializer.
- Not defined: WAIT_START waits indefinitely; counter logic omitted; err tied 0.

Test Plan:
- Single request: req=4'b0010, data1=16'hA5C3 -> one tw_write with tw_din=16'hA5C3, grant_id=1, ack=4'b0010 one cycle after busy falls, active low GAP cycles later.
- All four requesting continuously, distinct data 16'h1111..16'h4444 -> grants in order 0,1,2,3,0; exactly one ack per frame; write-to-write gap >= frame + GAP.
- Request drop: req0 raised then dropped the cycle after ISSUE -> frame still sent, ack[0] pulses, next grant goes to req1 if pending.
- Reset mid-frame: assert rst_n low during WAIT_DONE -> all outputs 0 immediately; after release with req=4'b0100, first grant is 2, pointer restarted at 0.
- Busy high at idle: hold tw_busy=1 with req=4'b0001 -> no tw_write until busy drops, then normal frame.
- With TW_ARB_TIMEOUT_EN, busy stuck at 0: req=4'b1000 -> err=1 at START_WAIT cycles after tw_write, ack[3] pulses, arbiter returns to IDLE; without macro, state stays WAIT_START and err stays 0.
